// File: rtl/fir_param.sv
// Parametrised direct-form FIR filter with run-time loadable coefficients.
// One output per accepted sample (after warm-up), rounded half up, registered.
// Optional build macro FIR_SAT_EN: saturate the rounded result to OUT_W bits
// instead of wrapping.
module fir_param #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned TAPS   = 32,
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned SHIFT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              clear,
  input  logic              coef_we,
  input  logic [5:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data
);

  // One spare bit above the exact accumulator width absorbs the rounding add.
  localparam int unsigned AccW = DATA_W + COEF_W + $clog2(TAPS);
  localparam int unsigned CntW = $clog2(TAPS + 1);

  localparam logic signed [AccW:0] RndC = {{AccW{1'b0}}, 1'b1} << (SHIFT - 1);

  logic [DATA_W-1:0] x_q    [TAPS];
  logic [DATA_W-1:0] x_d    [TAPS];
  logic [DATA_W-1:0] x_tap  [TAPS];
  logic [COEF_W-1:0] coef_q [TAPS];
  logic [COEF_W-1:0] coef_d [TAPS];
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;

  logic signed [AccW:0] acc;
  logic signed [AccW:0] acc_rnd;
  logic [OUT_W-1:0]     out_sample;

  // Delay line as it will look after the incoming sample is shifted in.
  always_comb begin
    x_tap[0] = in_data;
    for (int k = 1; k < TAPS; k++) begin
      x_tap[k] = x_q[k-1];
    end
  end

  // Multiply-accumulate over the post-shift taps with the current coefficients.
  always_comb begin
    acc = '0;
    for (int k = 0; k < TAPS; k++) begin
      acc = acc + (AccW + 1)'($signed(coef_q[k]) * $signed(x_tap[k]));
    end
    acc_rnd = acc + RndC;
  end

  // Scale the rounded accumulator down to OUT_W bits.
`ifdef FIR_SAT_EN
  localparam logic signed [AccW:0] OutMax =
      {{(AccW + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [AccW:0] OutMin =
      {{(AccW + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};
  logic signed [AccW:0] r;
  always_comb begin
    r = acc_rnd >>> SHIFT;
    if (r > OutMax) begin
      out_sample = OutMax[OUT_W-1:0];
    end else if (r < OutMin) begin
      out_sample = OutMin[OUT_W-1:0];
    end else begin
      out_sample = r[OUT_W-1:0];
    end
  end
`else
  always_comb begin
    out_sample = OUT_W'(acc_rnd >>> SHIFT);
  end
`endif

  // Delay line update; clear wins over a coincident sample.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      x_d[k] = x_q[k];
    end
    if (clear) begin
      for (int k = 0; k < TAPS; k++) begin
        x_d[k] = '0;
      end
    end else if (in_valid) begin
      for (int k = 0; k < TAPS; k++) begin
        x_d[k] = x_tap[k];
      end
    end
  end

  // Coefficient writes; out-of-range addresses match no tap and are dropped.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      coef_d[k] = coef_q[k];
      if (coef_we && (coef_addr == 6'(k))) begin
        coef_d[k] = coef_data;
      end
    end
  end

  // Warm-up counter and output strobe; a sample qualifies once it is the TAPS-th.
  always_comb begin
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    if (clear) begin
      cnt_d = '0;
    end else if (in_valid) begin
      if (cnt_q != CntW'(TAPS)) begin
        cnt_d = cnt_q + CntW'(1);
      end
      if (cnt_q >= CntW'(TAPS - 1)) begin
        out_valid_d = 1'b1;
        out_data_d  = out_sample;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        x_q[k]    <= '0;
        coef_q[k] <= '0;
      end
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      for (int k = 0; k < TAPS; k++) begin
        x_q[k]    <= x_d[k];
        coef_q[k] <= coef_d[k];
      end
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule
